// File: rtl/tristate_bus_reader.sv
// Receive side of the shared tristate data bus: captures enabled bus words into a
// small FIFO, presents them with valid/ready, throttles the driver and flags drops.
module tristate_bus_reader #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_y,
    input  logic             bus_en,
    output logic             bus_hold,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   HOLD_LVL = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             full;
    logic             pop;
    logic             push;
    logic             ovf_evt;

    // A pop at the same edge frees the slot, so a push into a full FIFO is still accepted.
    always_comb begin
        full      = (count == FULL_LVL);
        pop       = out_valid && out_ready;
        push      = bus_en && (!full || pop);
        ovf_evt   = bus_en && full && !pop;
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_y;
        end
    end

    // Hold looks at the post-edge occupancy so a driver reacting one cycle late still fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bus_hold <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_nxt;
            bus_hold <= (count_nxt >= HOLD_LVL);
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Scoreboard bench for tristate_bus_reader: expected words are queued as they are
// driven onto the bus and popped when the FIFO presents them downstream.
module tb_tristate_bus_reader;

    logic       clk;
    logic       rst_n;
    logic [3:0] bus_y;
    logic       bus_en;
    logic       bus_hold;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_w;

    tristate_bus_reader #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_y    (bus_y),
        .bus_en   (bus_en),
        .bus_hold (bus_hold),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic step(input logic en, input logic [3:0] y, input logic rdy, input logic clr);
        bus_en    = en;
        bus_y     = en ? y : 4'bzzzz;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
        bus_en    = 1'b0;
        bus_y     = 4'bzzzz;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic fill(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        logic [3:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[i]);
            step(1'b1, w[i], 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 16) begin
            exp_w = exp_q.pop_front();
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_w) begin
                bad++;
                $display("FAIL %s drain: valid=%b data=%b, required valid=1 data=%b", name, out_valid, out_data, exp_w);
            end
            step(1'b0, 4'b0000, 1'b1, 1'b0);
            guard++;
        end
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL %s empty: valid=%b count=%0d, required valid=0 count=0", name, out_valid, count);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus_en = 1'b0; bus_y = 4'bzzzz; out_ready = 1'b0; clr_ovf = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0 || bus_hold !== 1'b0 || overflow !== 1'b0 || out_data !== 4'd0) begin
            bad++;
            $display("FAIL reset_state: valid=%b count=%0d hold=%b ovf=%b data=%b, required 0 0 0 0 0000",
                     out_valid, count, bus_hold, overflow, out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 1'b0, 1'b0);
            total++;
            if (out_valid !== 1'b0 || count !== 3'd0 || bus_hold !== 1'b0 || overflow !== 1'b0) begin
                bad++;
                $display("FAIL idle_z cycle %0d: valid=%b count=%0d hold=%b ovf=%b, required all 0",
                         i, out_valid, count, bus_hold, overflow);
            end
        end
    endtask

    task automatic test_single;
        exp_q.push_back(4'b1010);
        step(1'b1, 4'b1010, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0] || count !== 3'd1 || bus_hold !== 1'b0) begin
            bad++;
            $display("FAIL single_word: valid=%b data=%b count=%0d hold=%b, required 1 1010 1 0",
                     out_valid, out_data, count, bus_hold);
        end
        drain("single");
    endtask

    task automatic test_burst;
        exp_q.push_back(4'b0000); step(1'b1, 4'b0000, 1'b0, 1'b0);
        exp_q.push_back(4'b1010); step(1'b1, 4'b1010, 1'b0, 1'b0);
        total++;
        if (bus_hold !== 1'b0 || count !== 3'd2) begin
            bad++;
            $display("FAIL burst_two: hold=%b count=%0d, required hold=0 count=2", bus_hold, count);
        end
        exp_q.push_back(4'b0110); step(1'b1, 4'b0110, 1'b0, 1'b0);
        total++;
        if (bus_hold !== 1'b1 || count !== 3'd3) begin
            bad++;
            $display("FAIL burst_hold: hold=%b count=%0d, required hold=1 count=3", bus_hold, count);
        end
        exp_q.push_back(4'b1111); step(1'b1, 4'b1111, 1'b0, 1'b0);
        total++;
        if (count !== 3'd4 || bus_hold !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL burst_full: count=%0d hold=%b ovf=%b, required 4 1 0", count, bus_hold, overflow);
        end
        drain("burst");
        total++;
        if (bus_hold !== 1'b0) begin
            bad++;
            $display("FAIL burst_hold_release: hold=%b, required 0", bus_hold);
        end
    endtask

    task automatic test_overflow;
        fill(4'b1001, 4'b0010, 4'b0100, 4'b1000);
        step(1'b1, 4'b0101, 1'b0, 1'b0);
        total++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b count=%0d, required ovf=1 count=4", overflow, count);
        end
        step(1'b1, 4'b0101, 1'b0, 1'b1);
        total++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_set_wins: ovf=%b count=%0d, required ovf=1 count=4", overflow, count);
        end
        drain("overflow");
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: ovf=%b, required 1", overflow);
        end
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop;
        fill(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        exp_w = exp_q.pop_front();
        total++;
        if (out_data !== exp_w) begin
            bad++;
            $display("FAIL fullpp_head: data=%b, required %b", out_data, exp_w);
        end
        exp_q.push_back(4'b0011);
        step(1'b1, 4'b0011, 1'b1, 1'b0);
        total++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL fullpp_count: count=%0d ovf=%b, required count=4 ovf=0", count, overflow);
        end
        drain("fullpp");
    endtask

    task automatic test_back_to_back;
        logic [3:0] w;
        for (int i = 0; i < 10; i++) begin
            w = 4'((i * 7 + 3) % 16);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_q.push_back(w);
            step(1'b1, w, 1'b1, 1'b0);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || count !== 3'd1) begin
                bad++;
                $display("FAIL stream word %0d: valid=%b data=%b count=%0d, required 1 %b 1",
                         i, out_valid, out_data, count, exp_q[0]);
            end
        end
        drain("stream");
        exp_q.push_back(4'b1100); step(1'b1, 4'b1100, 1'b0, 1'b0);
        exp_q.push_back(4'b0111); step(1'b1, 4'b0111, 1'b0, 1'b0);
        total++;
        if (count !== 3'd2 || out_data !== exp_q[0]) begin
            bad++;
            $display("FAIL prereset_fill: count=%0d data=%b, required count=2 data=%b", count, out_data, exp_q[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0 || bus_hold !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: valid=%b count=%0d hold=%b, required 0 0 0", out_valid, count, bus_hold);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL post_reset_release: valid=%b count=%0d, required 0 0", out_valid, count);
        end
        exp_q.push_back(4'b0110);
        step(1'b1, 4'b0110, 1'b0, 1'b0);
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tristate_bus_reader.md
Name: tristate_bus_reader

Overview:
- Receive side of the shared 4-bit tristate data bus.
- A remote agent's tristate buffer drives the bus and raises its enable. This block captures each enabled bus word into a small FIFO and presents words downstream with a valid/ready handshake.
- It never drives the bus. It returns a hold signal to throttle the remote driver, and it flags words lost because the driver ignored hold.

Parameters:
- WIDTH, 4, bus and data word width in bits.
- DEPTH, 4, FIFO depth in words; a power of two, at least 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock, single domain.
- rst_n  input  1  asynchronous active-low reset.
- bus_y  input  WIDTH  shared bus value, sampled only while bus_en=1.
- bus_en  input  1  remote driver enable; 1 means bus_y carries a valid word this cycle.
- bus_hold  output  1  backpressure to the remote driver; 1 means do not present words.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag; a word arrived while the FIFO was full.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately): pointers=0, count=0, out_valid=0, out_data=0, bus_hold=0, overflow=0. FIFO storage contents are don't-care.
- Reset asserted mid-stream discards all buffered words. No output may be valid in the cycle after reset release.
- Capture (push): on a rising edge with bus_en=1 and count<DEPTH, write bus_y at the write pointer and increment it. One word per enabled cycle.
- Capture is level-based, not edge-based: bus_en held high for N cycles pushes N words.
- bus_y is ignored whenever bus_en=0, so high-Z or X on the bus while idle must not affect state.
- Pop: on a rising edge with out_valid=1 and out_ready=1, increment the read pointer.
- out_ready while out_valid=0 has no effect.
- Output timing:
  - out_data = storage[read pointer].
  - out_valid = (count != 0).
  - Both are combinational from registered state, with no bypass.
  - A word captured at edge k is first visible with out_valid=1 after edge k, giving 1-cycle latency from bus to output.
- Simultaneous push and pop in the same edge: both occur and count is unchanged. This holds when full (pop frees the slot at the same edge, so the push is accepted) and when count=1.
- When empty, push only; pop is impossible.
- Pointers wrap modulo DEPTH. count is kept as a separate register, or derived from AW+1-bit pointers.
- count is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- bus_hold is registered, 1 when count ≥ DEPTH−1 after the current edge.
  - This gives the remote driver one cycle of slack: a driver that samples hold and stops next cycle never overflows.
- Overflow: on an edge with bus_en=1, count=DEPTH and no simultaneous pop:
  - The word is dropped.
  - Storage and pointers are unchanged.
  - overflow is set to 1.
- Clearing overflow:
  - overflow stays 1 until clr_ovf=1 at an edge.
  - If clr_ovf=1 and a new overflow event occur at the same edge, overflow stays 1 (set wins).
- No internal state machine beyond the FIFO. Block states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH), implied by count.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n=0 for 2 cycles, release, bus_en=0 with bus_y=4'bzzzz for 5 cycles.
   - Required: out_valid=0, count=0, bus_hold=0, overflow=0 throughout.
2. Single word:
   - Stimulus: bus_y=4'b1010, bus_en=1 for one cycle, out_ready=0.
   - Required: after that edge out_valid=1, out_data=4'b1010, count=1. Then out_ready=1 for one cycle gives out_valid=0, count=0.
3. Burst and order:
   - Stimulus: bus_en=1 for 4 cycles with bus_y=0000, 1010, 0110, 1111, out_ready=0.
   - Required: count reaches 4. bus_hold=1 after the 3rd push. Draining with out_ready=1 yields 0000, 1010, 0110, 1111 in order.
4. Overflow:
   - Stimulus: with the FIFO full and out_ready=0, bus_en=1 with bus_y=0101 for one cycle.
   - Required: overflow=1, count stays 4, and drained data excludes 0101. A following clr_ovf=1 pulse gives overflow=0.
5. Full with simultaneous push and pop:
   - Stimulus: FIFO full, out_ready=1, bus_en=1 with bus_y=0011.
   - Required: count stays 4, overflow stays 0, and 0011 is the last word drained.
6. Wrap and reset mid-operation:
   - Stimulus: 10 words streamed with out_ready=1 continuously, then 2 words pushed with out_ready=0, then rst_n pulsed low asynchronously between clock edges.
   - Required: during the stream, output equals input delayed 1 cycle across pointer wrap. On reset, out_valid=0 and count=0 immediately, and the 2 buffered words are lost.
